// File: rtl/sprite_palette_pkg.sv
// rtl/sprite_palette_pkg.sv - shared types and constants for the sprite palette bank
package sprite_palette_pkg;

  localparam int PKG_CH_W = 4;

  typedef struct packed {
    logic [PKG_CH_W-1:0] r;
    logic [PKG_CH_W-1:0] g;
    logic [PKG_CH_W-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } flash_state_t;

  localparam rgb_t WHITE = '1;

  localparam rgb_t DEFAULT_PALETTE [16] = '{
    12'h2C7, 12'hF0F, 12'h000, 12'hFFF,
    12'hF00, 12'hE33, 12'h0F0, 12'h00F,
    12'hFF0, 12'h0FF, 12'h888, 12'h444,
    12'hCCC, 12'h840, 12'h48C, 12'h1C6
  };

endpackage

// File: rtl/sprite_palette_bank_flash_fsm.sv
// rtl/sprite_palette_bank_flash_fsm.sv - frame-timed hit-flash sequencer (ON/OFF phases)
module palette_flash_fsm
  import sprite_palette_pkg::*;
#(
  parameter int FLASH_PERIOD = 4,
  parameter int FLASH_COUNT  = 3
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_tick,
  input  logic flash_req,
  output logic flash_on,
  output logic flash_busy
);

  localparam int PH_W  = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam int CYC_W = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT) : 1;

  flash_state_t     state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ph_q    <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cyc_d   = cyc_q;
    // A new hit always restarts the whole sequence, even over a same-cycle tick.
    if (flash_req) begin
      state_d = ON;
      ph_d    = '0;
      cyc_d   = '0;
    end else if (frame_tick) begin
      case (state_q)
        ON: begin
          if (ph_q == PH_W'(FLASH_PERIOD - 1)) begin
            state_d = OFF;
            ph_d    = '0;
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
        OFF: begin
          if (ph_q == PH_W'(FLASH_PERIOD - 1)) begin
            ph_d = '0;
            if (cyc_q == CYC_W'(FLASH_COUNT - 1)) begin
              state_d = IDLE;
              cyc_d   = '0;
            end else begin
              state_d = ON;
              cyc_d   = cyc_q + 1'b1;
            end
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign flash_on   = (state_q == ON);
  assign flash_busy = (state_q != IDLE);

endmodule

// File: rtl/sprite_palette_bank.sv
// rtl/sprite_palette_bank.sv - multi-bank runtime-writable sprite palette with transparency and hit flash
module sprite_palette_bank
  import sprite_palette_pkg::*;
#(
  parameter int IDX_W        = 4,
  parameter int CH_W         = PKG_CH_W,
  parameter int BANKS        = 2,
  parameter int TRANSP_IDX   = 1,
  parameter int FLASH_PERIOD = 4,
  parameter int FLASH_COUNT  = 3,
  localparam int BANK_W      = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [3*CH_W-1:0] wr_rgb,
  input  logic              rd_valid,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic              frame_tick,
  input  logic              flash_req,
  output logic              out_valid,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              out_transparent,
  output logic              flash_busy
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [3*CH_W-1:0] mem_q [BANKS][DEPTH];
  logic [3*CH_W-1:0] mem_d [BANKS][DEPTH];
  logic              out_valid_q, out_valid_d;
  logic [3*CH_W-1:0] rgb_q, rgb_d;
  logic              transp_q, transp_d;
  logic              flash_on;
  logic              wr_bank_ok;
  logic [BANK_W-1:0] rd_bank_eff;

  palette_flash_fsm #(
    .FLASH_PERIOD(FLASH_PERIOD),
    .FLASH_COUNT (FLASH_COUNT)
  ) u_flash (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_tick(frame_tick),
    .flash_req (flash_req),
    .flash_on  (flash_on),
    .flash_busy(flash_busy)
  );

  assign wr_bank_ok  = ({1'b0, wr_bank} < (BANK_W + 1)'(BANKS));
  assign rd_bank_eff = ({1'b0, rd_bank} < (BANK_W + 1)'(BANKS)) ? rd_bank : '0;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int b = 0; b < BANKS; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[b][i] <= DEFAULT_PALETTE[i % 16];
        end
      end
      out_valid_q <= 1'b0;
      rgb_q       <= '0;
      transp_q    <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      out_valid_q <= out_valid_d;
      rgb_q       <= rgb_d;
      transp_q    <= transp_d;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_en && wr_bank_ok) begin
      mem_d[wr_bank][wr_idx] = wr_rgb;
    end
  end

  // Lookup reads mem_q, so a same-cycle write to the same entry shows up on the next read.
  always_comb begin
    out_valid_d = rd_valid;
    rgb_d       = rgb_q;
    transp_d    = transp_q;
    if (rd_valid) begin
      transp_d = (rd_idx == IDX_W'(TRANSP_IDX));
      rgb_d    = (flash_on && !transp_d) ? WHITE : mem_q[rd_bank_eff][rd_idx];
    end
  end

  assign out_valid          = out_valid_q;
  assign {red, green, blue} = rgb_q;
  assign out_transparent    = transp_q;

endmodule

// File: doc/sprite_palette_bank.md
Name: sprite_palette_bank

Overview:
- Runtime-writable, multi-bank colour palette for sprite rendering. Maps a per-pixel colour index to 4:4:4 RGB with one-cycle registered latency.
- Sits between each sprite ROM index output and the VGA colour mux.
- Banks give per-player recolouring of one sprite set.
- Adds a transparency flag and a frame-timed hit-flash effect that forces visible pixels to white.

Parameters:
- IDX_W, 4, colour index width; depth = 2**IDX_W entries per bank.
- CH_W, 4, bits per colour channel.
- BANKS, 2, number of palette banks (player channels).
- TRANSP_IDX, 1, index reported as transparent.
- FLASH_PERIOD, 4, frame_tick count per flash half-phase (ON or OFF), >=1.
- FLASH_COUNT, 3, ON/OFF cycles per flash request, >=1.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  synchronous, active-low reset.
- wr_en  in  1  palette write strobe.
- wr_bank  in  $clog2(BANKS)  bank to write.
- wr_idx  in  IDX_W  entry to write.
- wr_rgb  in  3*CH_W  {R,G,B} write data.
- rd_valid  in  1  pixel lookup request.
- rd_bank  in  $clog2(BANKS)  bank to look up.
- rd_idx  in  IDX_W  pixel colour index.
- frame_tick  in  1  one-cycle pulse per frame (vsync edge).
- flash_req  in  1  one-cycle pulse that starts or restarts the hit flash.
- out_valid  out  1  red/green/blue/out_transparent valid.
- red, green, blue  out  CH_W each  pixel colour.
- out_transparent  out  1  pixel index equals TRANSP_IDX.
- flash_busy  out  1  flash FSM is not IDLE.

Behaviour:
- Reset (Reset_n low at a Clk edge):
  - All banks load DEFAULT_PALETTE: entry0=2C7, entry1=F0F, entry5=E33, entry15=1C6, remaining entries per the package.
  - out_valid, red, green, blue and out_transparent reset to 0.
  - Flash FSM goes to IDLE and all counters clear.
  - Reset mid-flash aborts the flash immediately.
- Write:
  - When wr_en=1, entry [wr_bank][wr_idx] takes wr_rgb at the clock edge.
  - A wr_bank >= BANKS is ignored.
- Read:
  - Latency is 1 cycle.
  - out_valid(t+1) = rd_valid(t).
  - Colour(t+1) = entry[rd_bank][rd_idx] as stored before the edge at t, i.e. read-before-write. A write and a read to the same entry in one cycle returns the old value.
  - When rd_valid=0, red/green/blue/out_transparent hold their previous values.
  - A rd_bank >= BANKS reads bank 0.
- Transparency:
  - out_transparent is set from the index compare rd_idx==TRANSP_IDX, not from the colour value.
  - A recoloured TRANSP_IDX entry is still flagged transparent.
- Flash FSM, states IDLE, ON, OFF; phase counter ph (0..FLASH_PERIOD-1); cycle counter cyc (0..FLASH_COUNT-1):
  - IDLE, flash_req: go to ON, ph=0, cyc=0.
  - ON, frame_tick: ph increments. At ph==FLASH_PERIOD-1, go to OFF with ph=0.
  - OFF, frame_tick: ph increments. At ph==FLASH_PERIOD-1:
    - if cyc==FLASH_COUNT-1, go to IDLE;
    - otherwise go to ON with cyc+1 and ph=0.
  - flash_req in any non-IDLE state restarts to ON with ph=0 and cyc=0. flash_req takes priority over a same-cycle frame_tick.
  - flash_busy = (state != IDLE), combinational from the state register.
- Flash effect:
  - The state is sampled at lookup time t.
  - If state==ON and the index is not TRANSP_IDX, the output colour is all-ones on every channel (FFF).
  - Transparent pixels are never whitened.
  - The flash applies to all banks.
- Width rules:
  - No arithmetic is performed on colour.
  - Counters are sized $clog2 of their limit with a minimum width of 1.
  - Total flash duration is 2*FLASH_PERIOD*FLASH_COUNT frame_ticks.

Decomposition:
- Package sprite_palette_pkg holds:
  - the rgb_t packed struct of three CH_W fields;
  - DEFAULT_PALETTE as a 16-entry rgb_t constant;
  - the flash_state_t enum {IDLE, ON, OFF};
  - WHITE = all-ones.
- Sub-module palette_flash_fsm contains the state, ph and cyc registers. It takes Clk, Reset_n, frame_tick and flash_req and outputs flash_on and flash_busy.
- The top level contains the bank register file, the read register and the transparency/flash output mux.

Test Plan:
- Reset, then rd_valid=1 with bank0 idx5 -> next cycle out_valid=1 and RGB=E33. With idx1 -> RGB=F0F and out_transparent=1.
- Write bank1 idx0=F00, then read bank1 idx0 -> F00. Read bank0 idx0 -> 2C7, confirming banks are independent.
- Same cycle: write bank0 idx15=ABC and read bank0 idx15 -> that read returns 1C6; the next read returns ABC.
- flash_req pulse, then idx0 reads each frame with FLASH_PERIOD=4, FLASH_COUNT=3:
  - RGB=FFF for frames 0-3, 2C7 for frames 4-7, pattern repeating;
  - flash_busy falls after the 24th frame_tick;
  - idx1 reads stay F0F throughout.
- flash_req mid-OFF on cycle 2 -> FSM returns to ON, ph=0, cyc=0, and a full 24-tick duration restarts.
- Reset_n low during ON -> next cycle flash_busy=0, out_valid=0, RGB=000, and bank1 idx0 back to its default 2C7.
